// File: rtl/image_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_frame_ctrl_if : valid/ready beat stream with end-of-frame marker      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface image_frame_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, output data, output last, input  ready);
  modport slave  (input  valid, input  data, input  last, output ready);
endinterface
`default_nettype wire

// File: rtl/image_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_frame_ctrl : frame-length controller with a 2-entry skid FIFO         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module image_frame_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset,
  input  logic                   cfg_start,
  input  logic [CNT_WIDTH-1:0]   cfg_beats,
  image_frame_ctrl_if.slave      s_axis,
  image_frame_ctrl_if.master     m_axis,
  output logic                   busy,
  output logic                   done,
  output logic                   err_len,
  output logic [CNT_WIDTH-1:0]   beat_cnt
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_data_q [2];
  logic [DATA_WIDTH-1:0] mem_data_d [2];
  logic [1:0]            mem_last_q, mem_last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  logic                  in_ready;
  logic                  out_valid;
  logic                  in_hs;
  logic                  out_hs;
  logic                  is_last_beat;

  // Ready depends only on registered state, so m_axis.ready never reaches s_axis.ready.
  assign in_ready     = (state_q == c_st_run) && (occ_q != 2'd2);
  assign out_valid    = (occ_q != 2'd0);
  assign in_hs        = s_axis.valid && in_ready;
  assign out_hs       = out_valid && m_axis.ready;
  assign is_last_beat = (cnt_q == (len_q - c_cnt_one));

  assign s_axis.ready = in_ready;
  assign m_axis.valid = out_valid;
  assign m_axis.data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign m_axis.last  = out_valid && mem_last_q[rd_ptr_q];

  assign busy     = (state_q == c_st_run) || (state_q == c_st_drain);
  assign done     = (state_q == c_st_done);
  assign err_len  = err_q;
  assign beat_cnt = cnt_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    mem_data_d = mem_data_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;

    // The last tag comes from our own count; the upstream marker is only cross-checked.
    if (in_hs) begin
      mem_data_d[wr_ptr_q] = s_axis.data;
      mem_last_d[wr_ptr_q] = is_last_beat;
      wr_ptr_d             = ~wr_ptr_q;
      cnt_d                = cnt_q + c_cnt_one;
      if (s_axis.last != is_last_beat) begin
        err_d = 1'b1;
      end
    end
    if (out_hs) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({in_hs, out_hs})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      c_st_idle: begin
        if (cfg_start) begin
          if (cfg_beats != '0) begin
            len_d   = cfg_beats;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = c_st_run;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      c_st_run: begin
        if (in_hs && is_last_beat) begin
          state_d = c_st_drain;
        end
      end
      c_st_drain: begin
        if (occ_q == 2'd0) begin
          state_d = c_st_done;
        end
      end
      c_st_done: state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q       <= c_st_idle;
      len_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_last_q    <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      mem_data_q[0] <= mem_data_d[0];
      mem_data_q[1] <= mem_data_d[1];
      mem_last_q    <= mem_last_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_image_frame_ctrl : directed self-checking bench for image_frame_ctrl     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_image_frame_ctrl;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 16;

  logic                 axi_clk;
  logic                 axi_reset;
  logic                 cfg_start;
  logic [CNT_WIDTH-1:0] cfg_beats;
  logic                 busy;
  logic                 done;
  logic                 err_len;
  logic [CNT_WIDTH-1:0] beat_cnt;

  int n_checks;
  int n_errors;

  image_frame_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) s_if ();
  image_frame_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) m_if ();

  image_frame_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_dut (
    .axi_clk   (axi_clk),
    .axi_reset (axi_reset),
    .cfg_start (cfg_start),
    .cfg_beats (cfg_beats),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len),
    .beat_cnt  (beat_cnt)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_s_ready"}, s_if.ready, 0);
    check_val({tag, "_m_valid"}, m_if.valid, 0);
    check_val({tag, "_m_data"},  m_if.data, 0);
    check_val({tag, "_m_last"},  m_if.last, 0);
    check_val({tag, "_busy"},    busy, 0);
    check_val({tag, "_done"},    done, 0);
    check_val({tag, "_err"},     err_len, 0);
    check_val({tag, "_cnt"},     beat_cnt, 0);
  endtask

  // rmode 0: downstream always ready; 1: ready toggles every cycle starting high.
  // bad_idx flips the upstream last marker on that beat; start_at injects a cfg_start mid-run.
  task automatic run_frame(input string tag, input int n, input int rmode, input int bad_idx,
                           input int start_at, input logic exp_err, input logic [31:0] base);
    logic [32:0] exp_q[$];
    logic [32:0] head;
    int          idx;
    int          outs;
    int          occ;
    int          cyc;
    logic        hs_in;
    logic        hs_out;

    s_if.valid   = 1'b0;
    cfg_start    = 1'b1;
    cfg_beats    = CNT_WIDTH'(n);
    tick();
    cfg_start    = 1'b0;
    check_val({tag, "_busy_start"}, busy, 1);
    check_val({tag, "_err_start"},  err_len, 0);
    check_val({tag, "_cnt_start"},  beat_cnt, 0);

    idx  = 0;
    outs = 0;
    occ  = 0;
    cyc  = 0;
    m_if.ready  = 1'b1;
    s_if.valid  = 1'b1;
    s_if.data   = base;
    s_if.last   = (n == 1) ^ (bad_idx == 0);

    while (outs < n && cyc < 200) begin
      hs_in  = s_if.valid && s_if.ready;
      hs_out = m_if.valid && m_if.ready;
      if (hs_out) begin
        head = exp_q.pop_front();
        check_val({tag, "_out_data"}, m_if.data, head[31:0]);
        check_val({tag, "_out_last"}, m_if.last, head[32]);
        outs++;
      end
      if (hs_in) exp_q.push_back({(idx == n - 1), s_if.data});
      tick();
      cyc++;
      if (hs_in) begin
        if (occ == 0 && !hs_out) check_val({tag, "_latency"}, m_if.data, s_if.data);
        idx++;
      end
      occ = occ + (hs_in ? 1 : 0) - (hs_out ? 1 : 0);
      check_val({tag, "_m_valid"}, m_if.valid, (occ != 0));
      check_val({tag, "_s_ready"}, s_if.ready, (idx < n) && (occ < 2));
      cfg_start = (cyc == start_at);
      cfg_beats = (cyc == start_at) ? CNT_WIDTH'(9) : CNT_WIDTH'(n);
      s_if.valid = (idx < n);
      s_if.data  = base + 32'(idx);
      s_if.last  = (idx == n - 1) ^ (idx == bad_idx);
      if (rmode == 1) m_if.ready = ~m_if.ready;
    end
    check_val({tag, "_beats_out"}, outs, n);
    cfg_start  = 1'b0;
    s_if.valid = 1'b0;

    // Drain sees the empty buffer one edge later, then DONE lasts a single cycle.
    check_val({tag, "_drain_busy"}, busy, 1);
    check_val({tag, "_drain_done"}, done, 0);
    tick();
    check_val({tag, "_done_pulse"}, done, 1);
    check_val({tag, "_done_busy"},  busy, 0);
    tick();
    check_val({tag, "_done_clear"}, done, 0);
    check_val({tag, "_beat_cnt"},   beat_cnt, n);
    check_val({tag, "_err_len"},    err_len, exp_err);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    axi_reset    = 1'b1;
    cfg_start    = 1'b0;
    cfg_beats    = '0;
    s_if.valid   = 1'b0;
    s_if.data    = '0;
    s_if.last    = 1'b0;
    m_if.ready   = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    axi_reset = 1'b0;
    tick();

    run_frame("f4", 4, 0, -1, -1, 1'b0, 32'h1000_0000);
    run_frame("f8t", 8, 1, -1, -1, 1'b0, 32'hA5A5_0000);

    cfg_start = 1'b1;
    cfg_beats = '0;
    tick();
    cfg_start = 1'b0;
    check_val("zero_err",  err_len, 1);
    check_val("zero_busy", busy, 0);
    check_val("zero_rdy",  s_if.ready, 0);
    tick();
    check_val("zero_idle", busy, 0);
    run_frame("f1", 1, 0, -1, -1, 1'b0, 32'hDEAD_BEEF);

    run_frame("early", 3, 0, 1, -1, 1'b1, 32'h0300_0000);
    run_frame("nolast", 2, 0, 1, -1, 1'b1, 32'h0200_0000);

    // Mid-frame reset with beats held in the buffer.
    cfg_start = 1'b1;
    cfg_beats = CNT_WIDTH'(16);
    tick();
    cfg_start  = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 32'h5500_0000;
    s_if.last  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic hs;
      m_if.ready = (i < 5);
      hs = s_if.valid && s_if.ready;
      tick();
      if (hs) s_if.data = s_if.data + 32'd1;
    end
    check_val("mid_busy",  busy, 1);
    check_val("mid_valid", m_if.valid, 1);
    axi_reset = 1'b1;
    tick();
    axi_reset  = 1'b0;
    s_if.valid = 1'b0;
    check_reset_outputs("midrst");
    run_frame("post", 2, 0, -1, -1, 1'b0, 32'h7700_0000);

    run_frame("ign", 5, 0, -1, 2, 1'b0, 32'h0900_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/image_frame_ctrl.md
IMAGE_FRAME_CTRL -- requirements
Module: image_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, stream data width in bits (4 pixels of 8 bits).
REQ-002 Parameter CNT_WIDTH, default 16, width of frame beat count.
REQ-003 axi_clk  in  1  single clock; all logic on rising edge.
REQ-004 axi_reset  in  1  synchronous, active-high reset.
REQ-005 cfg_start  in  1  one-cycle frame start request.
REQ-006 cfg_beats  in  CNT_WIDTH  beats per frame, sampled on accepted cfg_start.
REQ-007 s_axis_valid  in  1  upstream (DMA) beat valid.
REQ-008 s_axis_data  in  DATA_WIDTH  upstream beat data.
REQ-009 s_axis_last  in  1  upstream end-of-frame marker.
REQ-010 s_axis_ready  out  1  controller can accept a beat.
REQ-011 m_axis_valid  out  1  beat valid toward the pixel inverter.
REQ-012 m_axis_data  out  DATA_WIDTH  beat data, unmodified.
REQ-013 m_axis_last  out  1  asserted on the final beat of the frame.
REQ-014 m_axis_ready  in  1  downstream ready.
REQ-015 busy  out  1  high in RUN and DRAIN.
REQ-016 done  out  1  one-cycle pulse at frame completion.
REQ-017 err_len  out  1  sticky framing error flag; cleared only by reset or accepted cfg_start.
REQ-018 beat_cnt  out  CNT_WIDTH  beats accepted in current or last frame.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE: s_axis_ready=0; cfg_start with cfg_beats!=0 latches length, clears beat_cnt and err_len, enters RUN next cycle.
REQ-021 IDLE: cfg_start with cfg_beats==0 sets err_len and stays IDLE.
REQ-022 cfg_start outside IDLE is ignored; no state, count or flag change.
REQ-023 Input handshake = s_axis_valid && s_axis_ready; output handshake = m_axis_valid && m_axis_ready.
REQ-024 Beats pass through a 2-entry FIFO skid buffer; data and order preserved; no beat dropped or duplicated.
REQ-025 s_axis_ready = (state==RUN) && (occupancy<2), derived from registered state only, no combinational path from m_axis_ready.
REQ-026 Latency: a beat accepted at edge N with empty buffer is on m_axis_data with m_axis_valid=1 after edge N, i.e. in cycle N+1.
REQ-027 m_axis_valid = (occupancy!=0); m_axis_data/m_axis_last hold stable while m_axis_valid && !m_axis_ready.
REQ-028 Simultaneous input and output handshake in one cycle leaves occupancy unchanged.
REQ-029 beat_cnt increments by 1 per input handshake in RUN; never exceeds latched length.
REQ-030 Beat whose index equals length-1 is tagged last; m_axis_last=1 only with that beat.
REQ-031 Accepting the tagged last beat moves RUN->DRAIN; s_axis_ready=0 from next cycle.
REQ-032 s_axis_last=1 on a beat of index != length-1 sets err_len; frame continues to full length.
REQ-033 s_axis_last=0 on the beat of index length-1 sets err_len; frame still ends at length.
REQ-034 DRAIN: when occupancy reaches 0, go DONE; DONE asserts done for exactly one cycle, then IDLE.
REQ-035 Length 1 frame: RUN accepts one beat, last tagged, DRAIN, DONE.
REQ-036 Length 2^CNT_WIDTH-1 supported; counter never wraps.

Reset
REQ-037 With axi_reset=1 at an edge: state IDLE, occupancy 0, s_axis_ready=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0, busy=0, done=0, err_len=0, beat_cnt=0.
REQ-038 Reset mid-frame discards buffered beats and takes effect at that edge, overriding all other inputs.

Verification
REQ-039 Reset, cfg_start with cfg_beats=4, continuous valid, m_axis_ready=1 -> 4 beats out in order, first one cycle after first accept, m_axis_last only on 4th, done one cycle after DRAIN empties, beat_cnt=4.
REQ-040 cfg_beats=8, m_axis_ready toggled 1/0 every cycle -> s_axis_ready drops at occupancy 2, all 8 data words out unchanged, no duplicates.
REQ-041 cfg_beats=0 -> err_len=1, state IDLE, busy=0; then cfg_start cfg_beats=1 -> err_len cleared, single beat with m_axis_last=1, done pulse.
REQ-042 cfg_beats=3, s_axis_last=1 on beat 2 -> err_len=1, 3 beats out, m_axis_last on beat 3 only.
REQ-043 cfg_beats=16, axi_reset=1 after 5 beats with m_axis_ready=0 -> next cycle all outputs at reset values; new frame of 2 beats completes normally.
REQ-044 cfg_start pulsed during RUN with cfg_beats=9 -> ignored, original length frame completes.
